// File: rtl/main_pipe_ctrl.sv
// Issue/retire controller for a fixed-latency kernel pipeline fed by two joined input streams.
// A tag shift register mirrors the kernel so we know which output beats carry real items.
module main_pipe_ctrl #(
  parameter int PIPE_LAT = 4,
  parameter int CNTW     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] n_items,
  input  logic            in0_valid,
  input  logic            in1_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            stall,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]          state_reg, state_next;
  logic [CNTW-1:0]     issued_reg, retired_reg, n_cap_reg;
  logic [PIPE_LAT-1:0] vtag_reg, vtag_next;
  logic                active, tail, can_adv, issue, retire;

  assign active  = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign tail    = vtag_reg[PIPE_LAT-1];
  assign can_adv = active && (!tail || out_ready);
  assign issue   = (state_reg == ST_RUN) && in0_valid && in1_valid &&
                   (issued_reg < n_cap_reg) && can_adv;
  assign retire  = tail && out_ready;

  assign in_ready  = issue;
  assign out_valid = tail;
  assign stall     = !can_adv;
  assign busy      = active;
  assign done      = (state_reg == ST_DONE);

  // Whole tag chain advances together with the kernel; a held tail freezes everything.
  assign vtag_next[0] = can_adv ? issue : vtag_reg[0];
  generate
    for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_tag
      assign vtag_next[gi] = can_adv ? vtag_reg[gi-1] : vtag_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = (n_items != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (issue && (issued_reg + CNTW'(1) == n_cap_reg)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (retire && (retired_reg + CNTW'(1) == n_cap_reg)) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      issued_reg  <= '0;
      retired_reg <= '0;
      n_cap_reg   <= '0;
      vtag_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DONE) begin
        issued_reg  <= '0;
        retired_reg <= '0;
        vtag_reg    <= '0;
      end else begin
        vtag_reg <= vtag_next;
        if (issue)  issued_reg  <= issued_reg + CNTW'(1);
        if (retire) retired_reg <= retired_reg + CNTW'(1);
      end
      // Item count is latched only when a run is accepted, so later changes are ignored.
      if (state_reg == ST_IDLE && start) n_cap_reg <= n_items;
    end
  end

endmodule

// File: tb/tb_main_pipe_ctrl.sv
// Directed bench for main_pipe_ctrl: per-cycle checks of {stall,in_ready,out_valid,busy,done}.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_main_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] n_items;
  logic        in0_valid, in1_valid;
  logic        in_ready, out_valid, out_ready;
  logic        stall, busy, done;

  int checks = 0;
  int errors = 0;

  main_pipe_ctrl #(.PIPE_LAT(4), .CNTW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .n_items(n_items),
    .in0_valid(in0_valid), .in1_valid(in1_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .stall(stall),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1; start = 1'b0; n_items = '0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      obs = {stall, in_ready, out_valid, busy, done};
      checks++;
      $display("reset cyc %0d obs=%b", k, obs);
      if (obs !== 5'b10000) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b expected %b", k, obs, 5'b10000);
      end
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [4:0] obs, exp;
    start = 1'b1; n_items = 32'd8; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) start = 1'b0;
      @(negedge clk);
      exp = {!(k >= 1 && k <= 12), (k >= 1 && k <= 8), (k >= 5 && k <= 12),
             (k >= 1 && k <= 12), (k == 13)};
      obs = {stall, in_ready, out_valid, busy, done};
      checks++;
      $display("basic cyc %0d obs=%b", k, obs);
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic cyc %0d: got %b expected %b", k, obs, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_zero();
    logic [4:0] obs;
    logic [4:0] tbl [4];
    tbl = '{5'b10000, 5'b10001, 5'b10000, 5'b10000};
    start = 1'b1; n_items = 32'd0; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) start = 1'b0;
      @(negedge clk);
      obs = {stall, in_ready, out_valid, busy, done};
      checks++;
      $display("zero cyc %0d obs=%b", k, obs);
      if (obs !== tbl[k]) begin
        errors++;
        $display("FAIL zero cyc %0d: got %b expected %b", k, obs, tbl[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] obs;
    logic [4:0] tbl [16];
    int rets, iss;
    tbl = '{5'b10000, 5'b01010, 5'b01010, 5'b01010, 5'b01010, 5'b10110, 5'b10110, 5'b10110,
            5'b01110, 5'b01110, 5'b00110, 5'b00110, 5'b00110, 5'b00110, 5'b10001, 5'b10000};
    rets = 0; iss = 0;
    start = 1'b1; n_items = 32'd6; in0_valid = 1'b1; in1_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) start = 1'b0;
      out_ready = !(k >= 5 && k <= 7);
      @(negedge clk);
      obs = {stall, in_ready, out_valid, busy, done};
      if (out_valid && out_ready) rets++;
      if (in_ready) iss++;
      checks++;
      $display("bp cyc %0d obs=%b", k, obs);
      if (obs !== tbl[k]) begin
        errors++;
        $display("FAIL bp cyc %0d: got %b expected %b", k, obs, tbl[k]);
      end
      next_cycle();
    end
    checks++;
    if (rets !== 6 || iss !== 6) begin
      errors++;
      $display("FAIL bp totals: got retires=%0d issues=%0d expected 6/6", rets, iss);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_underrun();
    logic [4:0] obs;
    logic [4:0] tbl [16];
    int rets;
    tbl = '{5'b10000, 5'b01010, 5'b00010, 5'b01010, 5'b00010, 5'b01110, 5'b00010, 5'b01110,
            5'b00010, 5'b01110, 5'b00010, 5'b00110, 5'b00010, 5'b00110, 5'b10001, 5'b10000};
    rets = 0;
    start = 1'b1; n_items = 32'd5; in0_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) start = 1'b0;
      in1_valid = (k % 2 == 1);
      @(negedge clk);
      obs = {stall, in_ready, out_valid, busy, done};
      if (out_valid && out_ready) rets++;
      checks++;
      $display("underrun cyc %0d obs=%b", k, obs);
      if (obs !== tbl[k]) begin
        errors++;
        $display("FAIL underrun cyc %0d: got %b expected %b", k, obs, tbl[k]);
      end
      next_cycle();
    end
    checks++;
    if (rets !== 5) begin
      errors++;
      $display("FAIL underrun retires: got %0d expected 5", rets);
    end
    in1_valid = 1'b1;
  endtask

  task automatic test_reset_midrun();
    logic [4:0] obs;
    logic [4:0] tbl_a [10];
    logic [4:0] tbl_b [9];
    tbl_a = '{5'b10000, 5'b01010, 5'b01010, 5'b01010, 5'b01010, 5'b00000,
              5'b10000, 5'b10000, 5'b10000, 5'b10000};
    tbl_b = '{5'b10000, 5'b01010, 5'b01010, 5'b00010, 5'b00010, 5'b00110,
              5'b00110, 5'b10001, 5'b10000};
    start = 1'b1; n_items = 32'd10; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) start = 1'b0;
      rst = (k == 5);
      @(negedge clk);
      obs = {stall, in_ready, out_valid, busy, done};
      $display("rstmid cyc %0d obs=%b", k, obs);
      if (k != 5) begin
        checks++;
        if (obs !== tbl_a[k]) begin
          errors++;
          $display("FAIL rstmid cyc %0d: got %b expected %b", k, obs, tbl_a[k]);
        end
      end
      next_cycle();
    end
    start = 1'b1; n_items = 32'd2;
    for (int k = 0; k < 9; k++) begin
      if (k == 1) start = 1'b0;
      @(negedge clk);
      obs = {stall, in_ready, out_valid, busy, done};
      checks++;
      $display("rerun cyc %0d obs=%b", k, obs);
      if (obs !== tbl_b[k]) begin
        errors++;
        $display("FAIL rerun cyc %0d: got %b expected %b", k, obs, tbl_b[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_restart_ignored();
    logic [4:0] obs;
    logic [4:0] tbl [11];
    tbl = '{5'b10000, 5'b01010, 5'b01010, 5'b01010, 5'b00010, 5'b00110,
            5'b00110, 5'b00110, 5'b10001, 5'b10000, 5'b10000};
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      start = (k == 0) || (k == 2) || (k == 8);
      n_items = (k == 0) ? 32'd3 : (k == 2) ? 32'd7 : 32'd5;
      @(negedge clk);
      obs = {stall, in_ready, out_valid, busy, done};
      checks++;
      $display("restart cyc %0d obs=%b", k, obs);
      if (obs !== tbl[k]) begin
        errors++;
        $display("FAIL restart cyc %0d: got %b expected %b", k, obs, tbl[k]);
      end
      next_cycle();
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_underrun();
    test_reset_midrun();
    test_restart_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_pipe_ctrl.md
MAIN_PIPE_CTRL -- requirements
Module: main_pipe_ctrl

Interface
REQ-001 Parameter: PIPE_LAT, default 4, fixed kernel pipeline latency in advancing cycles (legal 1..64).
REQ-002 Parameter: CNTW, default 32, width of item count and counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 n_items  input  CNTW  number of work-items in the run; captured on accepted start.
REQ-007 in0_valid / in1_valid  input  1 each  vin0 / vin1 stream word available.
REQ-008 in_ready  output  1  both input words consumed this cycle (joint pop).
REQ-009 out_valid  output  1  kernel output word (vout) valid this cycle.
REQ-010 out_ready  input  1  downstream accepts vout word.
REQ-011 stall  output  1  drives kernel stall; 1 = kernel pipeline holds.
REQ-012 busy  output  1  high in RUN or DRAIN.
REQ-013 done  output  1  one-cycle pulse at run completion.

Function
REQ-014 FSM states IDLE, RUN, DRAIN, DONE; state encoding is internal.
REQ-015 IDLE->RUN on start with n_items>0; IDLE->DONE on start with n_items==0; otherwise stay.
REQ-016 Block keeps tag shift register vtag[PIPE_LAT-1:0]; tail = vtag[PIPE_LAT-1]; out_valid = tail.
REQ-017 can_adv = (state is RUN or DRAIN) and (!tail or out_ready).
REQ-018 issue = state RUN and in0_valid and in1_valid and issued < n_items and can_adv.
REQ-019 in_ready = issue; inputs never popped individually.
REQ-020 stall = !can_adv; in IDLE and DONE stall = 1.
REQ-021 When can_adv: vtag shifts one place, vtag[0] <= issue (bubble tag 0 if no issue); otherwise vtag holds.
REQ-022 issued counter increments on issue; retired counter increments on out_valid and out_ready.
REQ-023 RUN->DRAIN on the cycle issue brings issued to n_items.
REQ-024 DRAIN->DONE on the cycle retire brings retired to n_items.
REQ-025 DONE: done=1 for exactly one cycle, counters and vtag cleared, next state IDLE.
REQ-026 Latency: with out_ready held high, item issued at cycle t has out_valid at t+PIPE_LAT.
REQ-027 Backpressure: tail valid with out_ready low freezes whole pipeline (stall=1, no issue) and holds out_valid high.
REQ-028 Input underrun (either valid low) in RUN inserts bubbles; pipeline continues draining, no stall.
REQ-029 start while busy or in DONE is ignored; n_items change mid-run has no effect.
REQ-030 Counters are CNTW bits; n_items up to 2^CNTW-1 never wraps before DONE.
REQ-031 Issue and retire in same cycle both counted; DRAIN entered even if retire occurs same cycle.

Reset
REQ-032 rst=1 forces IDLE, issued=retired=0, vtag=0, captured n_items=0.
REQ-033 Outputs during/after reset: stall=1, in_ready=0, out_valid=0, busy=0, done=0.
REQ-034 rst mid-run aborts run on next edge; in-flight tags discarded, no done pulse.

Verification
REQ-035 PIPE_LAT=4, n_items=8, inputs always valid, out_ready=1 -> in_ready high 8 cycles, out_valid high cycles 5..12 after start, done one cycle later, then IDLE.
REQ-036 n_items=0 start -> DONE next cycle, done pulse, no in_ready, no out_valid, stall stays 1.
REQ-037 n_items=6, out_ready low 3 cycles when first out_valid rises -> stall=1 and in_ready=0 those 3 cycles, out_valid held, total 6 retires, done after 6th.
REQ-038 n_items=5, in1_valid low every other cycle -> issues only when both valid, bubbles tagged 0, exactly 5 out_valid beats, done after 5th retire.
REQ-039 rst asserted 2 cycles after 3rd issue of 10-item run -> next cycle IDLE, outputs at reset values, no done; new start with n_items=2 completes normally.
REQ-040 start pulsed again during RUN with different n_items -> ignored; original run count honoured.
